rotate_key_ctrl: RTL and testbench
==================================

# rotate_key_ctrl

Consumes the debounced one-cycle key press pulses produced by the key debounce stage and turns them into the rotation command used by the image rotate datapath. Presses are accumulated between frames and committed only on a frame-start strobe, so the rotator never changes angle mid-frame. The block also drives the board LEDs as user feedback, showing the current angle one-hot and optionally blinking the pending target.

## Interface
Parameters:
- BLINK_HALF, 12_500_000, LED blink half-period in clk cycles (0.25 s at 50 MHz); must be ≥ 2.
- CNT_W, 24, width of the blink counter; must hold BLINK_HALF-1.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous reset, active-high.
- key_pulse  in  3  one-cycle press pulses, active-high; [0]=rotate CW, [1]=rotate CCW, [2]=home (angle 0).
- frame_start  in  1  one-cycle strobe at the start of each frame (from VSYNC logic).
- angle  out  2  committed rotation: 0=0°, 1=90°, 2=180°, 3=270°.
- angle_upd  out  1  one-cycle pulse in the cycle after a commit.
- pending  out  1  high while a command awaits frame_start.
- led  out  4  LED feedback, active-high.

## Operation
- Reset (rst sampled high on a clk edge): state IDLE, angle=0, angle_upd=0, pending=0, led=4'b0001, accumulator and home flag cleared, blink counter 0.
- Accumulator pend_delta[1:0], modulo 4: +1 on key_pulse[0], +3 on key_pulse[1]; both in the same cycle → no change (cancel), but the cycle still counts as an event.
- key_pulse[2] sets home flag and clears pend_delta. CW/CCW in the same cycle as home are applied after the clear (home + CW → target 1).
- Target = (home ? 0 : angle) + pend_delta, mod 4.
- States:
  - IDLE: any nonzero key_pulse → PEND (accumulator loaded that edge).
  - PEND: keeps accumulating. On frame_start, angle ← target, angle_upd ← 1, pend_delta and home cleared, → APPLY. Key events in that same cycle are not included in this commit; they load the cleared accumulator.
  - APPLY: lasts exactly one cycle. frame_start is ignored. Next state is PEND if any event was captured at the commit edge or in APPLY, else IDLE.
- A net-zero pending command, e.g. CW then CCW, still commits on frame_start and pulses angle_upd with angle unchanged.
- frame_start in IDLE has no effect.
- pending = (state==PEND).
- led: in IDLE and APPLY, one-hot of angle (led[angle]=1).

## Timing
- Key-to-commit latency is bounded only by frame_start. angle changes on the first clk edge where state==PEND and frame_start==1.
- angle_upd is high for the single cycle following that edge and is registered.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- rst asserted mid-PEND discards the pending command. angle returns to 0 on that same edge.
- Blink counter counts 0..BLINK_HALF-1 and wraps. Phase toggles on wrap. Counter and phase are cleared on every entry to PEND.

## Configuration
- LED_BLINK_EN defined: in PEND, led alternates between one-hot(target) (phase 0, the first BLINK_HALF cycles) and 4'b0000 (phase 1). On commit, led shows the new angle steady.
- LED_BLINK_EN undefined: the blink counter and sub-module are not instantiated. In PEND, led shows one-hot(target) steady.
- angle, angle_upd and pending behaviour is identical in both builds.

## Structure
- Shared package rotate_pkg holds:
  - the state enum (IDLE, PEND, APPLY);
  - key bit indices KEY_CW=0, KEY_CCW=1, KEY_HOME=2;
  - angle constants ANG_0..ANG_270;
  - the one-hot LED decode function.
- One sub-module, led_blink_timer, provides the parameterized half-period counter with a clear input and a phase output. It is instantiated only under LED_BLINK_EN.

## Test plan
- Reset, then CW pulse, then frame_start 10 cycles later → pending=1 for those cycles; angle=1 and angle_upd=1 for one cycle immediately after the commit edge; led=4'b0010.
- From angle=1: CW, CW, CCW, then frame_start → angle=2; a single angle_upd pulse.
- CW and CCW in the same cycle, then frame_start → angle unchanged, angle_upd still pulses once.
- From angle=3: home+CW in the same cycle, then frame_start → angle=1. Also, a CW arriving in the same cycle as frame_start is committed at the next frame_start, not this one.
- PEND with LED_BLINK_EN and BLINK_HALF=4, target 2 → led toggles between 4'b0100 and 4'b0000 every 4 cycles. The same stimulus without the macro → led steady at 4'b0100.
- rst asserted while PEND with target 3 → angle=0, pending=0 and led=4'b0001 on the next edge; a later frame_start produces no angle_upd.

Source files
------------

// File: rtl/rotate_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rotate_pkg
//  Brief    : Shared types, key indices, angle constants and LED decode for
//             the rotation key controller.
//  Revision : 1.0 - initial release
// ============================================================================
package rotate_pkg;

    // Controller states: waiting for keys, holding a command, commit cycle
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        APPLY = 2'd2
    } state_t;

    // Bit positions within the key pulse vector
    localparam int KEY_CW   = 0;
    localparam int KEY_CCW  = 1;
    localparam int KEY_HOME = 2;

    // Rotation codes driven to the rotate datapath
    localparam logic [1:0] ANG_0   = 2'd0;
    localparam logic [1:0] ANG_90  = 2'd1;
    localparam logic [1:0] ANG_180 = 2'd2;
    localparam logic [1:0] ANG_270 = 2'd3;

    // One LED per angle, lit for the given rotation code
    function automatic logic [3:0] angle_onehot(input logic [1:0] ang);
        angle_onehot = 4'b0001 << ang;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_blink_timer.sv
`default_nettype none
// ============================================================================
//  Module   : led_blink_timer
//  Brief    : Half-period counter 0..BLINK_HALF-1 with a synchronous clear;
//             the phase output toggles every time the counter wraps.
//             Compiled only when LED_BLINK_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`ifdef LED_BLINK_EN
module led_blink_timer #(
    parameter int BLINK_HALF = 12_500_000,
    parameter int CNT_W      = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic phase
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;

    // Free-running half-period count, restarted in phase 0 on clear
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == CNT_W'(BLINK_HALF - 1)) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign phase = r_phase;

endmodule
`endif
`default_nettype wire

// File: rtl/rotate_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rotate_key_ctrl
//  Brief    : Accumulates CW/CCW/home key presses and commits the resulting
//             rotation on frame_start; drives one-hot angle LEDs.
//             Build option LED_BLINK_EN: blink the pending target on the LEDs.
//  Revision : 1.0 - initial release
// ============================================================================
module rotate_key_ctrl
    import rotate_pkg::*;
#(
    parameter int BLINK_HALF = 12_500_000,
    parameter int CNT_W      = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] key_pulse,
    input  logic       frame_start,
    output logic [1:0] angle,
    output logic       angle_upd,
    output logic       pending,
    output logic [3:0] led
);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_angle, w_angle_nxt;
    logic [1:0] r_delta, w_delta_nxt;
    logic       r_home,  w_home_nxt;
    logic       r_upd,   w_upd_nxt;
    logic       r_evt,   w_evt_nxt;     // key event seen at commit edge
    logic       w_evt;
    logic       w_commit;
    logic [1:0] w_base_delta;
    logic       w_base_home;
    logic [1:0] w_target;
    logic       w_phase;
    logic [3:0] w_led;

    assign w_evt    = |key_pulse;
    assign w_commit = (r_state == PEND) && frame_start;
    assign w_target = (r_home ? ANG_0 : r_angle) + r_delta;

    // Accumulator update; a commit clears it first so same-cycle keys start a new command
    always_comb begin
        w_base_delta = w_commit ? 2'd0 : r_delta;
        w_base_home  = w_commit ? 1'b0 : r_home;
        w_home_nxt   = w_base_home | key_pulse[KEY_HOME];
        w_delta_nxt  = key_pulse[KEY_HOME] ? 2'd0 : w_base_delta;
        if (key_pulse[KEY_CW] && !key_pulse[KEY_CCW]) begin
            w_delta_nxt = w_delta_nxt + 2'd1;
        end else if (key_pulse[KEY_CCW] && !key_pulse[KEY_CW]) begin
            w_delta_nxt = w_delta_nxt + 2'd3;
        end
    end

    // Next state, commit of the target angle and the update pulse
    always_comb begin
        w_state_nxt = r_state;
        w_angle_nxt = r_angle;
        w_upd_nxt   = 1'b0;
        w_evt_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_evt) w_state_nxt = PEND;
            end
            PEND: begin
                if (frame_start) begin
                    w_angle_nxt = w_target;
                    w_upd_nxt   = 1'b1;
                    w_evt_nxt   = w_evt;
                    w_state_nxt = APPLY;
                end
            end
            APPLY: begin
                w_state_nxt = (r_evt || w_evt) ? PEND : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_angle <= ANG_0;
            r_delta <= 2'd0;
            r_home  <= 1'b0;
            r_upd   <= 1'b0;
            r_evt   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_angle <= w_angle_nxt;
            r_delta <= w_delta_nxt;
            r_home  <= w_home_nxt;
            r_upd   <= w_upd_nxt;
            r_evt   <= w_evt_nxt;
        end
    end

`ifdef LED_BLINK_EN
    logic w_blink_clr;

    // Restart the blink in its lit phase whenever a new pending period begins
    assign w_blink_clr = (w_state_nxt == PEND) && (r_state != PEND);

    led_blink_timer #(
        .BLINK_HALF (BLINK_HALF),
        .CNT_W      (CNT_W)
    ) u_blink (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_blink_clr),
        .phase (w_phase)
    );
`else
    logic [CNT_W-1:0] w_unused_half;

    // Blink timing parameters only matter in the blinking build
    assign w_unused_half = CNT_W'(BLINK_HALF - 1);
    assign w_phase       = 1'b0;
`endif

    // LED decode from registered state only: committed angle, or pending target
    always_comb begin
        w_led = angle_onehot(r_angle);
        if (r_state == PEND) begin
            w_led = w_phase ? 4'b0000 : angle_onehot(w_target);
        end
    end

    assign angle     = r_angle;
    assign angle_upd = r_upd;
    assign pending   = (r_state == PEND);
    assign led       = w_led;

endmodule
`default_nettype wire

// File: tb/tb_rotate_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rotate_key_ctrl
//  Brief    : Self-checking bench for rotate_key_ctrl: directed scenarios plus
//             random key/frame/reset traffic against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rotate_key_ctrl;

    localparam int BH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] key_pulse = 3'b000;
    logic       frame_start = 1'b0;
    logic [1:0] angle;
    logic       angle_upd;
    logic       pending;
    logic [3:0] led;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: committed angle, pending command and blink age
    int m_angle = 0;
    int m_delta = 0;
    bit m_home  = 0;
    bit m_pend  = 0;
    bit m_apply = 0;
    bit m_carry = 0;
    bit m_upd   = 0;
    int m_age   = 0;

    rotate_key_ctrl #(
        .BLINK_HALF (BH),
        .CNT_W      (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_pulse   (key_pulse),
        .frame_start (frame_start),
        .angle       (angle),
        .angle_upd   (angle_upd),
        .pending     (pending),
        .led         (led)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_target();
        return ((m_home ? 0 : m_angle) + m_delta) % 4;
    endfunction

    function automatic logic [3:0] m_led();
        logic [3:0] one;
        one = 4'b0001;
        if (!m_pend) return one << m_angle;
`ifdef LED_BLINK_EN
        if (((m_age / BH) % 2) == 1) return 4'b0000;
`endif
        return one << m_target();
    endfunction

    // Apply one clock edge worth of the behavioural rules
    task automatic model_step(input logic [2:0] k, input logic fs, input logic r);
        bit was_pend, ev, commit;
        if (r) begin
            m_angle = 0; m_delta = 0; m_home = 0;
            m_pend = 0; m_apply = 0; m_carry = 0; m_upd = 0; m_age = 0;
            return;
        end
        ev       = (k != 3'b000);
        was_pend = m_pend;
        commit   = m_pend && fs;
        m_upd    = commit;
        if (commit) begin
            m_angle = m_target();
            m_delta = 0;
            m_home  = 0;
        end
        if (k[2]) begin
            m_home  = 1;
            m_delta = 0;
        end
        m_delta = (m_delta + int'(k[0]) + 3 * int'(k[1])) % 4;
        if (commit) begin
            m_pend = 0; m_apply = 1; m_carry = ev;
        end else if (m_apply) begin
            m_apply = 0; m_pend = m_carry || ev;
        end else if (!was_pend) begin
            m_pend = ev;
        end
        if (m_pend && !was_pend) m_age = 0;
        else m_age++;
    endtask

    // One clock: drive inputs, advance the model, compare every output
    task automatic cyc(input logic [2:0] k, input logic fs, input logic r);
        @(negedge clk);
        key_pulse   = k;
        frame_start = fs;
        rst         = r;
        @(posedge clk);
        #1;
        model_step(k, fs, r);
        chk_val("angle",     32'(angle),     32'(m_angle));
        chk_val("angle_upd", 32'(angle_upd), 32'(m_upd));
        chk_val("pending",   32'(pending),   32'(m_pend));
        chk_val("led",       32'(led),       32'(m_led()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(3'b000, 1'b0, 1'b0);
    endtask

    initial begin
        int upd_cnt;
        logic [2:0] rk;
        logic rf, rr;

        cyc(3'b000, 1'b0, 1'b1);
        cyc(3'b000, 1'b0, 1'b1);
        chk_val("rst_angle", 32'(angle), 32'd0);
        chk_val("rst_led",   32'(led),   32'h1);
        chk_val("rst_pend",  32'(pending), 32'd0);
        chk_val("rst_upd",   32'(angle_upd), 32'd0);

        // CW, wait 10 cycles, commit
        cyc(3'b001, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(3'b000, 1'b0, 1'b0);
            chk_val("t1_pending", 32'(pending), 32'd1);
        end
        cyc(3'b000, 1'b1, 1'b0);
        chk_val("t1_angle", 32'(angle), 32'd1);
        chk_val("t1_upd",   32'(angle_upd), 32'd1);
        chk_val("t1_led",   32'(led), 32'h2);
        idle(2);

        // CW, CW, CCW then commit: one update pulse, angle 2
        cyc(3'b001, 1'b0, 1'b0);
        cyc(3'b001, 1'b0, 1'b0);
        cyc(3'b010, 1'b0, 1'b0);
        upd_cnt = 0;
        cyc(3'b000, 1'b1, 1'b0);
        upd_cnt += int'(angle_upd);
        for (int i = 0; i < 3; i++) begin
            cyc(3'b000, 1'b0, 1'b0);
            upd_cnt += int'(angle_upd);
        end
        chk_val("t2_angle", 32'(angle), 32'd2);
        chk_val("t2_updcnt", 32'(upd_cnt), 32'd1);

        // Simultaneous CW+CCW cancels but still commits
        cyc(3'b011, 1'b0, 1'b0);
        cyc(3'b000, 1'b1, 1'b0);
        chk_val("t3_angle", 32'(angle), 32'd2);
        chk_val("t3_upd",   32'(angle_upd), 32'd1);
        idle(2);

        // Reach 270, then home+CW gives 90
        cyc(3'b001, 1'b0, 1'b0);
        cyc(3'b000, 1'b1, 1'b0);
        chk_val("t4_angle3", 32'(angle), 32'd3);
        idle(2);
        cyc(3'b101, 1'b0, 1'b0);
        cyc(3'b000, 1'b1, 1'b0);
        chk_val("t4_home_cw", 32'(angle), 32'd1);
        idle(2);

        // CW coinciding with frame_start lands in the next commit
        cyc(3'b001, 1'b0, 1'b0);
        cyc(3'b001, 1'b1, 1'b0);
        chk_val("t4_first_commit", 32'(angle), 32'd2);
        idle(2);
        chk_val("t4_carry_pend", 32'(pending), 32'd1);
        cyc(3'b000, 1'b1, 1'b0);
        chk_val("t4_second_commit", 32'(angle), 32'd3);
        idle(2);

        // Pending target 180 on the LEDs
        cyc(3'b010, 1'b0, 1'b0);
        chk_val("t5_led_first", 32'(led), 32'h4);
        idle(BH);
`ifdef LED_BLINK_EN
        chk_val("t5_led_blink", 32'(led), 32'h0);
`else
        chk_val("t5_led_steady", 32'(led), 32'h4);
`endif
        idle(3);

        // Reset while pending target 270 discards it
        cyc(3'b001, 1'b0, 1'b0);
        cyc(3'b000, 1'b0, 1'b1);
        chk_val("t6_angle", 32'(angle), 32'd0);
        chk_val("t6_pend",  32'(pending), 32'd0);
        chk_val("t6_led",   32'(led), 32'h1);
        cyc(3'b000, 1'b1, 1'b0);
        chk_val("t6_noupd", 32'(angle_upd), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rk = ($urandom_range(0, 9) < 6) ? 3'b000 : 3'($urandom_range(0, 7));
            rf = ($urandom_range(0, 7) == 0);
            rr = ($urandom_range(0, 99) == 0);
            cyc(rk, rf, rr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
